// File: rtl/storage_access_arbiter_pkg.sv
// Shared types and storage timing constants for the chart/record storage arbiter.
package storage_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    localparam int STORAGE_ID_NONE = 0;
    localparam int STORAGE_RD_LAT  = 2;
    localparam int STORAGE_WR_LAT  = 1;

endpackage

// File: rtl/storage_access_arbiter_rr_picker.sv
// Round-robin pick: first asserted request searching ptr, ptr+1, ... mod N_REQ.
// Latency: combinational.
// Backpressure: none; caller decides when to use the pick.
module storage_access_arbiter_rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] pick_idx,
    output logic             any
);

    always_comb begin
        int               raw;
        logic [PTR_W-1:0] idx;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // Explicit wrap so non-power-of-2 N_REQ never indexes past the last requester.
            raw = int'(ptr) + k;
            if (raw >= N_REQ) raw = raw - N_REQ;
            idx = PTR_W'(raw);
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                pick_idx  = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/storage_access_arbiter.sv
// Shares one storage port among N_REQ requesters, round-robin, one access at a time.
// Latency: gnt 1 cycle after req sampled in IDLE; done RD_LAT/WR_LAT after gnt (same cycle for id 0).
// Backpressure: requests wait at req until granted; no queueing beyond the single owner.
module storage_access_arbiter
    import storage_access_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64,
    parameter int RD_LAT = STORAGE_RD_LAT,
    parameter int WR_LAT = STORAGE_WR_LAT
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              we,
    input  logic [N_REQ-1:0][ID_W-1:0]    id,
    input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              done,
    output logic                          err,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy,
    output logic [ID_W-1:0]               st_read_id,
    output logic [ID_W-1:0]               st_write_id,
    output logic [DATA_W-1:0]             st_wdata,
    input  logic [DATA_W-1:0]             st_rdata
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [ID_W-1:0] ID_NONE = ID_W'(STORAGE_ID_NONE);

    arb_state_t        state;
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  owner_oh;
    logic [PTR_W-1:0]  owner_idx;
    logic              we_q;
    logic              err_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] wdata_q;

    logic [N_REQ-1:0]  pick;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    storage_access_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req      (req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            owner_oh  <= '0;
            owner_idx <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            id_q      <= '0;
            wdata_q   <= '0;
            gnt       <= '0;
            rdata     <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        owner_oh  <= pick;
                        owner_idx <= pick_idx;
                        we_q      <= we[pick_idx];
                        id_q      <= id[pick_idx];
                        wdata_q   <= wdata[pick_idx];
                        gnt       <= pick;
                        cnt       <= '0;
                        // id 0 means "no access": skip storage and report err with done.
                        if (id[pick_idx] == ID_NONE) begin
                            err_q <= 1'b1;
                            state <= ARB_DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= ARB_ACCESS;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (we_q) begin
                        if (cnt == CNT_W'(WR_LAT - 1)) begin
                            cnt   <= '0;
                            state <= ARB_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        if (cnt == CNT_W'(RD_LAT - 1)) begin
                            rdata <= st_rdata;
                            cnt   <= '0;
                            state <= ARB_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ARB_DONE: begin
                    ptr   <= (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign done        = (state == ARB_DONE) ? owner_oh : '0;
    assign err         = (state == ARB_DONE) && err_q;
    assign busy        = (state != ARB_IDLE);
    assign st_read_id  = (state == ARB_ACCESS && !we_q) ? id_q : ID_NONE;
    assign st_write_id = (state == ARB_ACCESS &&  we_q) ? id_q : ID_NONE;
    assign st_wdata    = (state == ARB_ACCESS &&  we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Bench for storage_access_arbiter: directed table, hand-written corner sequences, random traffic vs a timeline model.
module tb_storage_access_arbiter;

    localparam int N  = 4;
    localparam int RL = 2;
    localparam int WL = 1;

    logic             clk = 1'b0;
    logic             sys_rst;
    logic [3:0]       req, we;
    logic [3:0][7:0]  id;
    logic [3:0][63:0] wdata;
    logic [3:0]       gnt, done;
    logic             err, busy;
    logic [63:0]      rdata, st_wdata, st_rdata;
    logic [7:0]       st_read_id, st_write_id;

    int n_cmp  = 0;
    int n_fail = 0;

    storage_access_arbiter dut (
        .clk(clk), .sys_rst(sys_rst), .req(req), .we(we), .id(id), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .st_read_id(st_read_id), .st_write_id(st_write_id), .st_wdata(st_wdata),
        .st_rdata(st_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic        wr;
        logic [7:0]  sid;
        logic [63:0] wd;
        logic [63:0] srd;
        int          done_off;
        logic        e;
        logic [7:0]  rid;
        logic [7:0]  wid;
        logic [63:0] rd;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; id = '0; wdata = '0; st_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sys_rst = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // ord packs the expected grant order, 2 bits per grant, first grant in bits [1:0].
    task automatic run_order(input logic [3:0] reqs, input logic [7:0] ord, input int n);
        logic [3:0] r;
        logic [1:0] w;
        int t;
        r = reqs;
        we = '0;
        id = {8'd4, 8'd3, 8'd2, 8'd1};
        req = r;
        for (int k = 0; k < n; k++) begin
            w = ord[2*k +: 2];
            t = 0;
            do begin
                @(posedge clk); #1;
                t++;
            end while (gnt == '0 && t < 20);
            check("order_gnt", 64'(gnt), 64'(onehot(w)));
            r = r & ~onehot(w);
            req = r;
        end
        wait_idle();
    endtask

    task automatic apply_vec(input vec_t v);
        logic [3:0] oh;
        clear_inputs();
        oh = onehot(v.idx);
        we[v.idx]    = v.wr;
        id[v.idx]    = v.sid;
        wdata[v.idx] = v.wd;
        st_rdata     = v.srd;
        req          = oh;
        for (int off = 1; off <= v.done_off + 1; off++) begin
            @(posedge clk); #1;
            if (off == 1) req = '0;
            check("vec_gnt",  64'(gnt),  64'((off == 1) ? oh : 4'b0));
            check("vec_done", 64'(done), 64'((off == v.done_off) ? oh : 4'b0));
            check("vec_err",  64'(err),  64'((off == v.done_off) ? v.e : 1'b0));
            check("vec_busy", 64'(busy), 64'(off <= v.done_off));
            check("vec_rid",  64'(st_read_id),  64'((off < v.done_off) ? v.rid : 8'd0));
            check("vec_wid",  64'(st_write_id), 64'((off < v.done_off) ? v.wid : 8'd0));
            if (v.wr && off < v.done_off) check("vec_wdata", st_wdata, v.wd);
            if (off >= v.done_off) check("vec_rdata", rdata, v.rd);
        end
    endtask

    // Random-phase requester state and reference timeline.
    logic [3:0]       r_req, r_we;
    logic [3:0][7:0]  r_id;
    logic [3:0][63:0] r_wd;
    logic [63:0]      m_cap, m_hold, m_wd;
    int  m_ptr, m_free, m_g, m_d, m_lat, m_owner, w;
    logic m_we, m_err;
    logic [7:0] m_id;

    initial begin
        sys_rst = 1'b1;
        clear_inputs();
        #1;
        check("rst_gnt",  64'(gnt),  64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err",  64'(err),  64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rdata", rdata, 64'(0));
        check("rst_rid",  64'(st_read_id),  64'(0));
        check("rst_wid",  64'(st_write_id), 64'(0));
        do_reset();

        // Contention from ptr 0, then one grant to move ptr to 1 before req=0101.
        run_order(4'b1111, 8'b11_10_01_00, 4);
        run_order(4'b0001, 8'b00_00_00_00, 1);
        run_order(4'b0101, 8'b00_00_00_10, 2);

        tbl[0] = '{2'd1, 1'b0, 8'd5,   64'h0,     64'hABCD, 1 + RL, 1'b0, 8'd5,   8'd0, 64'hABCD};
        tbl[1] = '{2'd3, 1'b1, 8'd7,   64'h1234,  64'h5555, 1 + WL, 1'b0, 8'd0,   8'd7, 64'hABCD};
        tbl[2] = '{2'd2, 1'b0, 8'd0,   64'h0,     64'h7777, 1,      1'b1, 8'd0,   8'd0, 64'hABCD};
        tbl[3] = '{2'd0, 1'b0, 8'd255, 64'h0,     '1,       1 + RL, 1'b0, 8'd255, 8'd0, '1};
        tbl[4] = '{2'd2, 1'b1, 8'd1,   64'hBEEF,  64'h0,    1 + WL, 1'b0, 8'd0,   8'd1, '1};
        for (int i = 0; i < 5; i++) apply_vec(tbl[i]);

        // req[0] held after its grant is a fresh request once the arbiter is back in IDLE.
        clear_inputs();
        id  = {8'd0, 8'd0, 8'd0, 8'd3};
        req = 4'b0001;
        for (int off = 1; off <= 6; off++) begin
            @(posedge clk); #1;
            check("held_gnt", 64'(gnt), 64'((off == 1 || off == 5) ? 4'b0001 : 4'b0000));
            check("held_ovl", 64'(st_read_id != 0 && st_write_id != 0), 64'(0));
            if (off == 5) req = '0;
        end
        wait_idle();

        // Reset in the middle of a read clears outputs immediately and restores ptr 0.
        clear_inputs();
        id  = {8'd0, 8'd0, 8'd5, 8'd0};
        req = 4'b0010;
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        check("mid_rid_pre", 64'(st_read_id), 64'(5));
        sys_rst = 1'b1;
        #1;
        check("mid_rid",  64'(st_read_id), 64'(0));
        check("mid_gnt",  64'(gnt),  64'(0));
        check("mid_done", 64'(done), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        sys_rst = 1'b0;
        run_order(4'b1001, 8'b00_00_11_00, 2);

        // Random traffic against a transaction timeline model.
        do_reset();
        r_req = '0; r_we = '0; r_id = '0; r_wd = '0;
        m_ptr = 0; m_free = 0; m_g = -100; m_d = -100; m_lat = 0; m_owner = 0;
        m_we = 1'b0; m_err = 1'b0; m_id = '0; m_wd = '0; m_cap = '0; m_hold = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == m_d && !m_err && !m_we) m_hold = m_cap;
            check("rnd_gnt",  64'(gnt),  64'((c == m_g) ? onehot(2'(m_owner)) : 4'b0));
            check("rnd_done", 64'(done), 64'((c == m_d) ? onehot(2'(m_owner)) : 4'b0));
            check("rnd_err",  64'(err),  64'(c == m_d && m_err));
            check("rnd_busy", 64'(busy), 64'(c >= m_g && c <= m_d));
            check("rnd_rid",  64'(st_read_id),
                  64'((!m_err && !m_we && c >= m_g && c < m_g + m_lat) ? m_id : 8'd0));
            check("rnd_wid",  64'(st_write_id),
                  64'((!m_err && m_we && c >= m_g && c < m_g + m_lat) ? m_id : 8'd0));
            if (!m_err && m_we && c >= m_g && c < m_g + m_lat) check("rnd_wdata", st_wdata, m_wd);
            check("rnd_rdata", rdata, m_hold);
            check("rnd_ovl", 64'(st_read_id != 0 && st_write_id != 0), 64'(0));

            if (c == m_g) r_req[2'(m_owner)] = 1'b0;
            for (int i = 0; i < N; i++) begin
                logic [1:0] b;
                b = 2'(i);
                if (!r_req[b] && !(c == m_g && i == m_owner) && $urandom_range(0, 3) == 0) begin
                    r_req[b] = 1'b1;
                    r_we[b]  = 1'($urandom_range(0, 1));
                    r_id[b]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    r_wd[b]  = {$urandom, $urandom};
                end
            end
            req = r_req; we = r_we; id = r_id; wdata = r_wd;
            st_rdata = {$urandom, $urandom};
            if (!m_err && !m_we && c == m_g + m_lat - 1) m_cap = st_rdata;

            if (c >= m_free && r_req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int x;
                    x = (m_ptr + k) % N;
                    if (w < 0 && r_req[2'(x)]) w = x;
                end
                m_owner = w;
                m_g     = c + 1;
                m_we    = r_we[2'(w)];
                m_id    = r_id[2'(w)];
                m_wd    = r_wd[2'(w)];
                m_err   = (m_id == 8'd0);
                m_lat   = m_err ? 0 : (m_we ? WL : RL);
                m_d     = m_g + m_lat;
                m_free  = m_d + 1;
                m_ptr   = (w + 1) % N;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
